data_island_packet_serializer: RTL and testbench

Downstream stage of every InfoFrame/packet generator: takes one 24-bit packet header and four 56-bit subpackets, appends the BCH error-correction bytes, and serializes the 32-slot packet over 32 pixel clocks as a 9-bit `packet_data` word per clock. The TMDS channel mapper consumes this output: bit 0 goes to channel 0 bit 2, bits 1–4 to channel 1, and bits 5–8 to channel 2. Header and subpackets are captured once per packet, so the upstream packet picker can advance on `packet_ack`.

---
 rtl/hdmi_packet_pkg.sv | 21 ++
 rtl/bch_ecc_step.sv | 12 +
 rtl/data_island_packet_serializer.sv | 120 ++++++++++++
 tb/tb_data_island_packet_serializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// rtl/hdmi_packet_pkg.sv - shared data-island packet geometry, BCH polynomial and lane map
package hdmi_packet_pkg;

  localparam logic [7:0] BCH_POLY     = 8'h83;
  localparam int         HEADER_BITS  = 24;
  localparam int         SUB_BITS     = 56;
  localparam int         PACKET_SLOTS = 32;
  localparam int         NUM_SUBS     = 4;
  localparam int         ECC_BITS     = 8;

  // packet_data lanes: header on bit 0, even subpacket bits on 1..4, odd on 5..8
  localparam int LANE_HDR      = 0;
  localparam int LANE_SUB_EVEN = 1;
  localparam int LANE_SUB_ODD  = 5;
  localparam int LANES         = 9;

  localparam logic [4:0] HDR_ECC_SLOT = 5'(HEADER_BITS);
  localparam logic [4:0] SUB_ECC_SLOT = 5'(SUB_BITS / 2);
  localparam logic [4:0] LAST_SLOT    = 5'(PACKET_SLOTS - 1);

endpackage

// File: rtl/bch_ecc_step.sv
// rtl/bch_ecc_step.sv - one bit-serial BCH parity update step
module bch_ecc_step
  import hdmi_packet_pkg::*;
(
  input  logic [ECC_BITS-1:0] i_ecc,
  input  logic                i_data,
  output logic [ECC_BITS-1:0] o_ecc_next
);

  assign o_ecc_next = {1'b0, i_ecc[ECC_BITS-1:1]} ^ ((i_ecc[0] ^ i_data) ? BCH_POLY : '0);

endmodule

// File: rtl/data_island_packet_serializer.sv
// rtl/data_island_packet_serializer.sv - captures header/subpackets, appends BCH, emits 9 bits per slot
module data_island_packet_serializer
  import hdmi_packet_pkg::*;
(
  input  logic                           clk_pixel,
  input  logic                           reset,
  input  logic                           data_island_period,
  input  logic [HEADER_BITS-1:0]         header,
  input  logic [NUM_SUBS*SUB_BITS-1:0]   sub,
  output logic                           packet_ack,
  output logic [LANES-1:0]               packet_data,
  output logic [4:0]                     counter,
  output logic                           packet_end
);

  logic [4:0]                         r_n;
  logic [HEADER_BITS-1:0]             r_header;
  logic [NUM_SUBS*SUB_BITS-1:0]       r_sub;
  logic [ECC_BITS-1:0]                r_hdr_ecc;
  logic [NUM_SUBS-1:0][ECC_BITS-1:0]  r_sub_ecc;

  logic                               w_first;
  logic                               w_in_hdr_data;
  logic                               w_in_sub_data;
  logic [HEADER_BITS-1:0]             w_hdr_src;
  logic [NUM_SUBS*SUB_BITS-1:0]       w_sub_src;
  logic                               w_hdr_bit;
  logic                               w_hdr_lane;
  logic [ECC_BITS-1:0]                w_hdr_ecc_cur;
  logic [ECC_BITS-1:0]                w_hdr_ecc_next;
  logic [NUM_SUBS-1:0][ECC_BITS-1:0]  w_sub_ecc_mid;
  logic [NUM_SUBS-1:0][ECC_BITS-1:0]  w_sub_ecc_next;
  logic [NUM_SUBS-1:0]                w_even;
  logic [NUM_SUBS-1:0]                w_odd;
  logic [LANES-1:0]                   w_slot_data;

  assign w_first       = (r_n == 5'd0);
  assign packet_ack    = data_island_period && w_first;
  assign w_in_hdr_data = (r_n < HDR_ECC_SLOT);
  assign w_in_sub_data = (r_n < SUB_ECC_SLOT);

  // Slot 0 reads the live inputs so the upstream picker can move on right after packet_ack
  assign w_hdr_src = w_first ? header : r_header;
  assign w_sub_src = w_first ? sub    : r_sub;

  assign w_hdr_ecc_cur = w_first ? '0 : r_hdr_ecc;
  assign w_hdr_bit     = w_in_hdr_data ? w_hdr_src[r_n] : 1'b0;
  assign w_hdr_lane    = w_in_hdr_data ? w_hdr_bit : r_hdr_ecc[r_n[2:0]];

  bch_ecc_step u_hdr_ecc (
    .i_ecc      (w_hdr_ecc_cur),
    .i_data     (w_hdr_bit),
    .o_ecc_next (w_hdr_ecc_next)
  );

  assign w_slot_data[LANE_HDR] = w_hdr_lane;

  for (genvar gi = 0; gi < NUM_SUBS; gi++) begin : g_sub
    logic [SUB_BITS-1:0] w_word;
    logic [ECC_BITS-1:0] w_ecc_cur;

    assign w_word    = w_sub_src[gi*SUB_BITS +: SUB_BITS];
    assign w_ecc_cur = w_first ? '0 : r_sub_ecc[gi];
    assign w_even[gi] = w_in_sub_data ? w_word[{r_n, 1'b0}] : 1'b0;
    assign w_odd[gi]  = w_in_sub_data ? w_word[{r_n, 1'b1}] : 1'b0;

    // Two chained steps per slot: bit 2n first, then bit 2n+1
    bch_ecc_step u_even (
      .i_ecc      (w_ecc_cur),
      .i_data     (w_even[gi]),
      .o_ecc_next (w_sub_ecc_mid[gi])
    );

    bch_ecc_step u_odd (
      .i_ecc      (w_sub_ecc_mid[gi]),
      .i_data     (w_odd[gi]),
      .o_ecc_next (w_sub_ecc_next[gi])
    );

    assign w_slot_data[LANE_SUB_EVEN+gi] = w_in_sub_data ? w_even[gi] : r_sub_ecc[gi][{r_n[1:0], 1'b0}];
    assign w_slot_data[LANE_SUB_ODD+gi]  = w_in_sub_data ? w_odd[gi]  : r_sub_ecc[gi][{r_n[1:0], 1'b1}];
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_n         <= '0;
      r_header    <= '0;
      r_sub       <= '0;
      r_hdr_ecc   <= '0;
      r_sub_ecc   <= '0;
      packet_data <= '0;
      counter     <= '0;
      packet_end  <= 1'b0;
    end else if (!data_island_period) begin
      // An island dropping mid-packet abandons it; the next island recaptures from slot 0
      r_n         <= '0;
      r_hdr_ecc   <= '0;
      r_sub_ecc   <= '0;
      packet_data <= '0;
      counter     <= '0;
      packet_end  <= 1'b0;
    end else begin
      r_n <= r_n + 5'd1;
      if (w_first) begin
        r_header <= header;
        r_sub    <= sub;
      end
      if (w_in_hdr_data) begin
        r_hdr_ecc <= w_hdr_ecc_next;
      end
      if (w_in_sub_data) begin
        r_sub_ecc <= w_sub_ecc_next;
      end
      packet_data <= w_slot_data;
      counter     <= r_n;
      packet_end  <= (r_n == LAST_SLOT);
    end
  end

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// tb/tb_data_island_packet_serializer.sv - randomized bench against a bit-serial packet model
module tb_data_island_packet_serializer;

  logic         clk_pixel = 1'b0;
  logic         reset = 1'b1;
  logic         data_island_period = 1'b0;
  logic [23:0]  header = '0;
  logic [223:0] sub = '0;
  logic         packet_ack;
  logic [8:0]   packet_data;
  logic [4:0]   counter;
  logic         packet_end;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_cnt = 0;
  int m       = 0;
  logic [8:0] exp_words [32];
  logic       obs_lane0 [32];

  data_island_packet_serializer dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .packet_ack         (packet_ack),
    .packet_data        (packet_data),
    .counter            (counter),
    .packet_end         (packet_end)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] bch(input logic [55:0] bits, input int nbits);
    logic [7:0] ecc = 8'h00;
    logic       fb;
    for (int k = 0; k < nbits; k++) begin
      fb  = ecc[0] ^ bits[k];
      ecc = ecc >> 1;
      if (fb) ecc = ecc ^ 8'h83;
    end
    return ecc;
  endfunction

  task automatic build_packet(input logic [23:0] h, input logic [223:0] s);
    logic [31:0] hb;
    logic [63:0] sw;
    hb = {bch(56'(h), 24), h};
    for (int n = 0; n < 32; n++) exp_words[n][0] = hb[n];
    for (int i = 0; i < 4; i++) begin
      sw = {bch(s[i*56 +: 56], 56), s[i*56 +: 56]};
      for (int n = 0; n < 32; n++) begin
        exp_words[n][1+i] = sw[2*n];
        exp_words[n][5+i] = sw[2*n+1];
      end
    end
  endtask

  function automatic logic [223:0] rand224();
    logic [223:0] r;
    for (int k = 0; k < 7; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One pixel clock: drive inputs, check packet_ack, then check the registered outputs
  task automatic tick(input logic rst, input logic dip, input logic [23:0] h, input logic [223:0] s);
    logic [8:0] e_data;
    logic [4:0] e_cnt;
    logic       e_end;
    reset = rst;
    data_island_period = dip;
    header = h;
    sub = s;
    #1;
    check("packet_ack", 32'(packet_ack), 32'(dip && (m == 0)));
    if (packet_ack) ack_cnt++;
    if (rst || !dip) begin
      e_data = '0; e_cnt = '0; e_end = 1'b0;
      m = 0;
    end else begin
      if (m == 0) build_packet(h, s);
      e_data = exp_words[m];
      e_cnt  = 5'(m);
      e_end  = (m == 31);
      m = (m + 1) % 32;
    end
    @(posedge clk_pixel);
    #1;
    cyc++;
    check("packet_data", 32'(packet_data), 32'(e_data));
    check("counter", 32'(counter), 32'(e_cnt));
    check("packet_end", 32'(packet_end), 32'(e_end));
    if (!rst && dip) obs_lane0[e_cnt] = packet_data[0];
  endtask

  task automatic run_packet(input logic [23:0] h, input logic [223:0] s, input int nslots, input bit scramble);
    tick(1'b0, 1'b1, h, s);
    for (int k = 1; k < nslots; k++) begin
      if (scramble) tick(1'b0, 1'b1, 24'($urandom), rand224());
      else          tick(1'b0, 1'b1, h, s);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 24'($urandom), rand224());
  endtask

  initial begin
    logic [7:0]   hecc;
    logic [23:0]  h;
    logic [223:0] s;

    @(posedge clk_pixel);
    #1;
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, '0, '0);
    idle(2);

    // null packet
    ack_cnt = 0;
    run_packet('0, '0, 32, 1'b0);
    check("null_ack_count", 32'(ack_cnt), 32'd1);
    idle(2);

    // AVI header: header ECC on lane 0 of slots 24..31 must be 8'hE4
    run_packet(24'h0D0282, '0, 32, 1'b0);
    for (int n = 0; n < 8; n++) hecc[n] = obs_lane0[24+n];
    check("avi_header_ecc", 32'(hecc), 32'h0000_00E4);
    idle(1);

    // capture isolation: inputs scrambled after slot 0
    run_packet(24'($urandom), rand224(), 32, 1'b1);
    idle(1);

    // back-to-back packets in one 64-cycle island
    ack_cnt = 0;
    run_packet(24'($urandom), rand224(), 32, 1'b1);
    run_packet(24'($urandom), rand224(), 32, 1'b1);
    check("b2b_ack_count", 32'(ack_cnt), 32'd2);
    idle(1);

    // abort at slot 10, re-raise after 3 cycles
    run_packet(24'($urandom), rand224(), 10, 1'b1);
    idle(3);
    run_packet(24'($urandom), rand224(), 32, 1'b1);
    idle(1);

    // reset asserted at slot 15
    h = 24'($urandom);
    s = rand224();
    run_packet(h, s, 15, 1'b0);
    tick(1'b1, 1'b1, h, s);
    idle(1);
    run_packet(24'($urandom), rand224(), 32, 1'b0);
    idle(1);

    // random back-to-back runs
    for (int p = 0; p < 4; p++) begin
      run_packet(24'($urandom), rand224(), 32, 1'b1);
      if (p[0]) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
